// File: rtl/clkmon_pkg.sv
// Shared encodings for the clock-monitor checker: frequency width, invalid marker, state codes.
package clkmon_pkg;

    localparam int FREQ_W = 16;
    localparam logic [FREQ_W-1:0] FREQ_INVALID = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_LOST    = 2'd3
    } state_t;

endpackage

// File: rtl/clkmon_tick_gen.sv
// Sample-rate tick: down-counter that pulses TICK for one cycle when it reaches zero, then reloads.
module clkmon_tick_gen #(
    parameter int P_CLK_FREQ = 100_000_000
) (
    input  logic CLK,
    input  logic RESET_N,
    output logic TICK
);

    localparam int CW = $clog2(P_CLK_FREQ);
    localparam logic [CW-1:0] RELOAD = CW'(P_CLK_FREQ - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == '0) ? RELOAD : cnt_q - CW'(1);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) cnt_q <= RELOAD;
        else          cnt_q <= cnt_d;
    end

    assign TICK = (cnt_q == '0);

endmodule

// File: rtl/clkmon_checker.sv
// Judges clock health from the monitor's measured frequency: windowed lock/loss qualification,
// sticky alarm and min/max statistics, all evaluated once per sample tick.
//   state   | meaning
//   UNKNOWN | no valid sample seen yet
//   ACQUIRE | counting consecutive in-range samples towards lock
//   LOCKED  | frequency qualified good; counting consecutive bad samples
//   LOST    | lock dropped; waiting for an in-range sample
module clkmon_checker
    import clkmon_pkg::*;
#(
    parameter int P_CLK_FREQ = 100_000_000,
    parameter int P_LOCK_CNT = 3,
    parameter int P_LOSS_CNT = 2
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [FREQ_W-1:0] MON_FREQ,
    input  logic [FREQ_W-1:0] CFG_FREQ_MIN,
    input  logic [FREQ_W-1:0] CFG_FREQ_MAX,
    input  logic              ALARM_CLR,
    input  logic              STATS_CLR,
    output logic              FREQ_OK,
    output logic              FREQ_ALARM,
    output logic [1:0]        FREQ_STATE,
    output logic [FREQ_W-1:0] FREQ_LAST,
    output logic [FREQ_W-1:0] FREQ_MIN_SEEN,
    output logic [FREQ_W-1:0] FREQ_MAX_SEEN,
    output logic              SAMPLE_STB
);

    localparam logic [3:0] LOCK_N = 4'(P_LOCK_CNT);
    localparam logic [3:0] LOSS_N = 4'(P_LOSS_CNT);

    logic tick;
    logic valid;
    logic in_rng;
    logic alarm_set;

    state_t state_q, state_d;
    logic [3:0] good_q, good_d;
    logic [3:0] bad_q, bad_d;
    logic ok_q, ok_d;
    logic alarm_q, alarm_d;
    logic stb_q, stb_d;
    logic [FREQ_W-1:0] last_q, last_d;
    logic [FREQ_W-1:0] min_q, min_d;
    logic [FREQ_W-1:0] max_q, max_d;

    clkmon_tick_gen #(.P_CLK_FREQ(P_CLK_FREQ)) u_tick_gen (
        .CLK     (CLK),
        .RESET_N (RESET_N),
        .TICK    (tick)
    );

    // An inverted window (MIN > MAX) can never satisfy both bounds, so in_rng stays 0.
    assign valid  = (MON_FREQ != FREQ_INVALID);
    assign in_rng = valid && (MON_FREQ >= CFG_FREQ_MIN) && (MON_FREQ <= CFG_FREQ_MAX);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= ST_UNKNOWN;
            good_q  <= '0;
            bad_q   <= '0;
            ok_q    <= 1'b0;
            alarm_q <= 1'b0;
            stb_q   <= 1'b0;
            last_q  <= FREQ_INVALID;
            min_q   <= FREQ_INVALID;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            ok_q    <= ok_d;
            alarm_q <= alarm_d;
            stb_q   <= stb_d;
            last_q  <= last_d;
            min_q   <= min_d;
            max_q   <= max_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        bad_d     = bad_q;
        alarm_set = 1'b0;
        if (tick) begin
            case (state_q)
                ST_UNKNOWN: begin
                    if (valid) begin
                        if (in_rng && LOCK_N == 4'd1) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                        end else begin
                            state_d = ST_ACQUIRE;
                            good_d  = {3'b000, in_rng};
                        end
                    end
                end
                ST_ACQUIRE: begin
                    if (in_rng) begin
                        if (good_q + 4'd1 == LOCK_N) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + 4'd1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (in_rng) begin
                        bad_d = '0;
                    end else if (bad_q + 4'd1 == LOSS_N) begin
                        state_d   = ST_LOST;
                        bad_d     = '0;
                        alarm_set = 1'b1;
                    end else begin
                        bad_d = bad_q + 4'd1;
                    end
                end
                ST_LOST: begin
                    if (in_rng) begin
                        if (LOCK_N == 4'd1) begin
                            state_d = ST_LOCKED;
                            good_d  = '0;
                        end else begin
                            state_d = ST_ACQUIRE;
                            good_d  = 4'd1;
                        end
                    end
                end
                default: state_d = ST_UNKNOWN;
            endcase
        end
    end

    always_comb begin
        ok_d    = (state_d == ST_LOCKED);
        stb_d   = tick;
        last_d  = tick ? MON_FREQ : last_q;
        alarm_d = alarm_q;
        if (alarm_set)      alarm_d = 1'b1;
        else if (ALARM_CLR) alarm_d = 1'b0;
        min_d = min_q;
        max_d = max_q;
        // A clear coincident with a valid sample restarts the statistics from that sample.
        if (STATS_CLR) begin
            min_d = (tick && valid) ? MON_FREQ : FREQ_INVALID;
            max_d = (tick && valid) ? MON_FREQ : '0;
        end else if (tick && valid) begin
            min_d = (MON_FREQ < min_q) ? MON_FREQ : min_q;
            max_d = (MON_FREQ > max_q) ? MON_FREQ : max_q;
        end
    end

    assign FREQ_OK       = ok_q;
    assign FREQ_ALARM    = alarm_q;
    assign FREQ_STATE    = state_q;
    assign FREQ_LAST     = last_q;
    assign FREQ_MIN_SEEN = min_q;
    assign FREQ_MAX_SEEN = max_q;
    assign SAMPLE_STB    = stb_q;

endmodule

// File: tb/tb_clkmon_checker.sv
// Self-checking bench for clkmon_checker: per-sample vector table with a scoreboard queue,
// plus hand sequences for off-tick clears and asynchronous reset.
module tb_clkmon_checker;

    typedef struct {
        logic [15:0] mon;
        logic [15:0] cmin;
        logic [15:0] cmax;
        logic        aclr;
        logic        sclr;
        logic [1:0]  st;
        logic        ok;
        logic        al;
        logic [15:0] last;
        logic [15:0] mn;
        logic [15:0] mx;
    } vec_t;

    localparam int NVEC = 32;

    logic        CLK;
    logic        RESET_N;
    logic [15:0] MON_FREQ;
    logic [15:0] CFG_FREQ_MIN;
    logic [15:0] CFG_FREQ_MAX;
    logic        ALARM_CLR;
    logic        STATS_CLR;
    logic        FREQ_OK;
    logic        FREQ_ALARM;
    logic [1:0]  FREQ_STATE;
    logic [15:0] FREQ_LAST;
    logic [15:0] FREQ_MIN_SEEN;
    logic [15:0] FREQ_MAX_SEEN;
    logic        SAMPLE_STB;

    vec_t vecs[NVEC];
    vec_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   pcnt;

    clkmon_checker #(.P_CLK_FREQ(10), .P_LOCK_CNT(3), .P_LOSS_CNT(2)) dut (
        .CLK           (CLK),
        .RESET_N       (RESET_N),
        .MON_FREQ      (MON_FREQ),
        .CFG_FREQ_MIN  (CFG_FREQ_MIN),
        .CFG_FREQ_MAX  (CFG_FREQ_MAX),
        .ALARM_CLR     (ALARM_CLR),
        .STATS_CLR     (STATS_CLR),
        .FREQ_OK       (FREQ_OK),
        .FREQ_ALARM    (FREQ_ALARM),
        .FREQ_STATE    (FREQ_STATE),
        .FREQ_LAST     (FREQ_LAST),
        .FREQ_MIN_SEEN (FREQ_MIN_SEEN),
        .FREQ_MAX_SEEN (FREQ_MAX_SEEN),
        .SAMPLE_STB    (SAMPLE_STB)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Cycles since reset release; the sample tick falls in cycles where pcnt % 10 == 9.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) pcnt <= 0;
        else          pcnt <= pcnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [15:0] mon, input logic [15:0] cmin,
                                input logic [15:0] cmax, input logic aclr, input logic sclr,
                                input logic [1:0] st, input logic ok, input logic al,
                                input logic [15:0] last, input logic [15:0] mn,
                                input logic [15:0] mx);
        vec_t v;
        v.mon = mon;  v.cmin = cmin; v.cmax = cmax; v.aclr = aclr; v.sclr = sclr;
        v.st = st;    v.ok = ok;     v.al = al;     v.last = last; v.mn = mn; v.mx = mx;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_state"}, 32'(FREQ_STATE), 32'd0);
        chk({tag, "_ok"},    32'(FREQ_OK), 32'd0);
        chk({tag, "_alarm"}, 32'(FREQ_ALARM), 32'd0);
        chk({tag, "_last"},  32'(FREQ_LAST), 32'hFFFF);
        chk({tag, "_min"},   32'(FREQ_MIN_SEEN), 32'hFFFF);
        chk({tag, "_max"},   32'(FREQ_MAX_SEEN), 32'h0000);
        chk({tag, "_stb"},   32'(SAMPLE_STB), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        check_reset(tag);
        @(negedge CLK);
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic do_sample(input int idx);
        vec_t v;
        vec_t e;
        int   early;
        int   n;
        bit   got;
        v = vecs[idx];
        MON_FREQ     = v.mon;
        CFG_FREQ_MIN = v.cmin;
        CFG_FREQ_MAX = v.cmax;
        sbq.push_back(v);
        early = 0;
        n     = 0;
        do begin
            @(negedge CLK);
            n++;
            if (SAMPLE_STB) early++;
        end while ((pcnt % 10) != 9 && n < 12);
        ALARM_CLR = v.aclr;
        STATS_CLR = v.sclr;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge CLK);
            ALARM_CLR = 1'b0;
            STATS_CLR = 1'b0;
            if (SAMPLE_STB) got = 1'b1;
        end
        chk($sformatf("v%0d_early_stb", idx), 32'(early), 32'd0);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL v%0d_stb_timeout actual=no_strobe required=strobe", idx);
            if (sbq.size() > 0) void'(sbq.pop_front());
        end else if (sbq.size() == 0) begin
            errors++;
            $display("FAIL v%0d_scoreboard_empty actual=strobe required=expectation", idx);
        end else begin
            e = sbq.pop_front();
            chk($sformatf("v%0d_state", idx), 32'(FREQ_STATE), 32'(e.st));
            chk($sformatf("v%0d_ok", idx),    32'(FREQ_OK), 32'(e.ok));
            chk($sformatf("v%0d_alarm", idx), 32'(FREQ_ALARM), 32'(e.al));
            chk($sformatf("v%0d_last", idx),  32'(FREQ_LAST), 32'(e.last));
            chk($sformatf("v%0d_min", idx),   32'(FREQ_MIN_SEEN), 32'(e.mn));
            chk($sformatf("v%0d_max", idx),   32'(FREQ_MAX_SEEN), 32'(e.mx));
        end
    endtask

    task automatic pulse_alarm_clr();
        @(negedge CLK);
        ALARM_CLR = 1'b1;
        @(negedge CLK);
        ALARM_CLR = 1'b0;
    endtask

    task automatic pulse_stats_clr();
        @(negedge CLK);
        STATS_CLR = 1'b1;
        @(negedge CLK);
        STATS_CLR = 1'b0;
    endtask

    initial begin
        // mon, min, max, aclr, sclr | state, ok, alarm, last, min_seen, max_seen
        for (int i = 0; i < 5; i++)
            vecs[i] = mk(16'hFFFF, 16'd95, 16'd105, 0, 0, 2'd0, 0, 0, 16'hFFFF, 16'hFFFF, 16'h0000);
        vecs[5]  = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd1, 0, 0, 16'd100, 16'd100, 16'd100);
        vecs[6]  = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd1, 0, 0, 16'd100, 16'd100, 16'd100);
        vecs[7]  = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd2, 1, 0, 16'd100, 16'd100, 16'd100);
        vecs[8]  = mk(16'd120, 16'd95, 16'd105, 0, 0, 2'd2, 1, 0, 16'd120, 16'd100, 16'd120);
        vecs[9]  = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd2, 1, 0, 16'd100, 16'd100, 16'd120);
        vecs[10] = mk(16'd120, 16'd95, 16'd105, 0, 0, 2'd2, 1, 0, 16'd120, 16'd100, 16'd120);
        vecs[11] = mk(16'd120, 16'd95, 16'd105, 0, 0, 2'd3, 0, 1, 16'd120, 16'd100, 16'd120);
        vecs[12] = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd1, 0, 1, 16'd100, 16'd100, 16'd120);
        vecs[13] = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd1, 0, 1, 16'd100, 16'd100, 16'd120);
        vecs[14] = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd2, 1, 1, 16'd100, 16'd100, 16'd120);
        vecs[15] = mk(16'd120, 16'd95, 16'd105, 0, 0, 2'd2, 1, 0, 16'd120, 16'd100, 16'd120);
        vecs[16] = mk(16'd120, 16'd95, 16'd105, 1, 0, 2'd3, 0, 1, 16'd120, 16'd100, 16'd120);
        vecs[17] = mk(16'd97,  16'd95, 16'd105, 0, 1, 2'd1, 0, 1, 16'd97,  16'd97,  16'd97);
        vecs[18] = mk(16'd97,  16'd95, 16'd105, 0, 0, 2'd1, 0, 1, 16'd97,  16'd97,  16'd97);
        vecs[19] = mk(16'd97,  16'd95, 16'd105, 0, 0, 2'd2, 1, 1, 16'd97,  16'd97,  16'd97);
        vecs[20] = mk(16'hFFFF, 16'd95, 16'd105, 0, 1, 2'd2, 1, 1, 16'hFFFF, 16'hFFFF, 16'h0000);
        vecs[21] = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd2, 1, 1, 16'd100, 16'd100, 16'd100);
        vecs[22] = mk(16'd90,  16'd95, 16'd105, 0, 0, 2'd2, 1, 1, 16'd90,  16'd90,  16'd100);
        vecs[23] = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd2, 1, 1, 16'd100, 16'd90,  16'd100);
        for (int i = 24; i < 28; i++)
            vecs[i] = mk(16'd107, 16'd110, 16'd105, 0, 0, 2'd1, 0, 0, 16'd107, 16'd107, 16'd107);
        vecs[28] = mk(16'hFFFF, 16'd95, 16'd105, 0, 0, 2'd0, 0, 0, 16'hFFFF, 16'hFFFF, 16'h0000);
        vecs[29] = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd1, 0, 0, 16'd100, 16'd100, 16'd100);
        vecs[30] = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd1, 0, 0, 16'd100, 16'd100, 16'd100);
        vecs[31] = mk(16'd100, 16'd95, 16'd105, 0, 0, 2'd2, 1, 0, 16'd100, 16'd100, 16'd100);

        RESET_N      = 1'b0;
        MON_FREQ     = 16'hFFFF;
        CFG_FREQ_MIN = 16'd95;
        CFG_FREQ_MAX = 16'd105;
        ALARM_CLR    = 1'b0;
        STATS_CLR    = 1'b0;
        repeat (3) @(negedge CLK);
        check_reset("por");
        RESET_N = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            do_sample(i);
            if (i == 14) begin
                pulse_alarm_clr();
                chk("mid_alarm_clr", 32'(FREQ_ALARM), 32'd0);
                chk("mid_alarm_clr_ok", 32'(FREQ_OK), 32'd1);
            end
            if (i == 23) begin
                pulse_stats_clr();
                chk("mid_stats_clr_min", 32'(FREQ_MIN_SEEN), 32'hFFFF);
                chk("mid_stats_clr_max", 32'(FREQ_MAX_SEEN), 32'h0000);
                chk("mid_stats_clr_state", 32'(FREQ_STATE), 32'd2);
                chk("mid_stats_clr_stb", 32'(SAMPLE_STB), 32'd0);
                pulse_alarm_clr();
                chk("mid_alarm_clr2", 32'(FREQ_ALARM), 32'd0);
                do_reset("rst_locked");
            end
            if (i == 27) begin
                repeat (4) @(negedge CLK);
                do_reset("rst_acquire");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
